inflate_wr_dma: RTL and testbench

- APB-programmed write-DMA engine: the AHB-master write counterpart to the inflate read path.
- Accepts 16-bit halfwords over a valid/ready stream, normally the inflate output FIFO (data_out/data_out_vld/data_out_rdy).
- Writes them to consecutive halfword addresses in system memory using single non-pipelined AHB NONSEQ halfword writes.
- Asserts a one-cycle done pulse after the programmed length has been written.

---
 rtl/inflate_wr_dma.sv | 171 +++++++++++++++++
 tb/tb_inflate_wr_dma.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inflate_wr_dma.sv
// APB-programmed write-DMA engine: drains a 16-bit valid/ready stream into
// consecutive halfword addresses using single non-pipelined AHB NONSEQ writes.
module inflate_wr_dma #(
  parameter int          LEN_WIDTH = 16,
  parameter logic [31:0] RST_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // APB slave
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  // AHB master
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  // halfword stream
  input  logic [15:0] data_in,
  input  logic        data_in_vld,
  output logic        data_in_rdy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  localparam logic [2:0] A_WRADDR = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_LEN    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [1:0]           state;
  logic [31:0]          wraddr;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] count;
  logic                 start;
  logic [15:0]          hold;
  logic [31:0]          prdata_q;
  logic                 done_q;

  logic        apb_wr;
  logic        apb_rd;
  logic        busy;
  logic [31:0] count_ext;
  logic [31:0] len_ext;
  logic [31:0] status_word;
  logic [31:0] rd_data;

  assign apb_wr    = PSEL &  PENABLE &  PWRITE;
  assign apb_rd    = PSEL & ~PENABLE & ~PWRITE;
  assign busy      = (state != S_IDLE);
  assign count_ext = 32'(count);
  assign len_ext   = 32'(len);

  assign status_word = {count_ext[15:0], 15'b0, busy};

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    rd_data = 32'h0;
    case (PADDR[4:2])
      A_WRADDR: rd_data = wraddr;
      A_CTRL:   rd_data = {31'b0, start};
      A_LEN:    rd_data = len_ext;
      A_STATUS: rd_data = status_word;
      default:  rd_data = 32'h0;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values; the FSM section comes after the APB
  // section so its updates win when both touch the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wraddr   <= {RST_ADDR[31:1], 1'b0};
      len      <= '0;
      count    <= '0;
      start    <= 1'b0;
      hold     <= 16'h0;
      prdata_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (apb_rd) prdata_q <= rd_data;

      if (apb_wr) begin
        case (PADDR[4:2])
          A_WRADDR: if (!busy) wraddr <= {PWDATA[31:1], 1'b0};
          A_CTRL: begin
            start <= PWDATA[0];
            if (PWDATA[0]) count <= '0;
          end
          A_LEN:    if (!busy) len <= PWDATA[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state <= S_FETCH;
            end else begin
              start  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (!start) begin
            state <= S_IDLE;
          end else if (data_in_vld) begin
            hold  <= data_in;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          // Abort is only legal before the address phase is accepted.
          if (!start)      state <= S_IDLE;
          else if (HREADY) state <= S_DATA;
        end
        S_DATA: begin
          // A data phase in flight always completes, even if start dropped.
          if (HREADY) begin
            wraddr <= wraddr + 32'd2;
            len    <= len - LEN_ONE;
            count  <= count + LEN_ONE;
            if (len == LEN_ONE) begin
              start  <= 1'b0;
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else if (!start) begin
              state <= S_IDLE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign HADDR       = wraddr;
  assign HTRANS      = (state == S_ADDR && start) ? HT_NONSEQ : HT_IDLE;
  assign HWRITE      = (state == S_ADDR);
  assign HSIZE       = 3'b001;
  assign HWDATA      = {hold, hold};
  assign data_in_rdy = (state == S_FETCH) && start;
  assign done        = done_q;
  assign PRDATA      = prdata_q;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], count_ext[31:16]};

endmodule

// File: tb/tb_inflate_wr_dma.sv
// Randomized bench for inflate_wr_dma: a stream/address model predicts every
// AHB write, done pulse and register value after each transfer.
module tb_inflate_wr_dma;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic        data_in_vld = 1'b0;
  logic        data_in_rdy;
  logic        done;

  inflate_wr_dma #(.LEN_WIDTH(16), .RST_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY),
    .data_in(data_in), .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the halfwords offered in order, and where they must land.
  logic [15:0] stream[$];
  logic [31:0] exp_base;
  int          cons_i, wr_i, done_cnt, aphase_cnt, cyc_n;
  int          hr_mode, vld_mode;  // 0 low, 1 high, 2 random, 3 every 4th cycle
  logic        ph_pending, aw_pending;
  logic [31:0] ph_addr, aw_addr;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then observe what the next
  // rising edge will see.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    case (hr_mode)
      0:       HREADY = 1'b0;
      1:       HREADY = 1'b1;
      default: HREADY = ($urandom_range(0, 9) < 6);
    endcase
    case (vld_mode)
      0:       data_in_vld = 1'b0;
      1:       data_in_vld = 1'b1;
      3:       data_in_vld = (cyc_n % 4 == 0);
      default: data_in_vld = 1'($urandom_range(0, 1));
    endcase
    if (cons_i >= stream.size()) data_in_vld = 1'b0;
    data_in = data_in_vld ? stream[cons_i] : 16'($urandom);
    #1;
    if (rst) begin
      ph_pending = 1'b0;
      aw_pending = 1'b0;
    end else begin
      if (aw_pending) begin
        check("addr_wait_htrans", 32'(HTRANS), 32'h2);
        check("addr_wait_haddr", HADDR, aw_addr);
      end
      if (ph_pending) begin
        if (wr_i < stream.size()) begin
          check("hwdata", HWDATA, {stream[wr_i], stream[wr_i]});
          if (HREADY) begin
            check("haddr", ph_addr, exp_base + 32'(2 * wr_i));
            wr_i++;
            ph_pending = 1'b0;
          end
        end else begin
          check("extra_write", 32'(wr_i), 32'(stream.size() - 1));
          ph_pending = 1'b0;
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        check("hwrite", 32'(HWRITE), 32'h1);
        check("hsize", 32'(HSIZE), 32'h1);
        ph_pending = 1'b1;
        ph_addr    = HADDR;
        aphase_cnt++;
      end
      aw_pending = (HTRANS == 2'b10) && !HREADY;
      aw_addr    = HADDR;
      if (data_in_rdy) check("fetch_bus_idle", 32'(HTRANS), 32'h0);
      if (data_in_rdy && data_in_vld) cons_i++;
      if (done) done_cnt++;
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
    PADDR = {27'd0, a, 2'b00}; PWDATA = d;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    cyc();
    PENABLE = 1'b1;
    cyc();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
    PADDR = {27'd0, a, 2'b00};
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    cyc();
    PENABLE = 1'b1;
    cyc();
    d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Caller fills stream first; this programs the engine and kicks it off.
  task automatic start_xfer(input logic [31:0] base, input int hr, input int vld);
    cons_i = 0; wr_i = 0; done_cnt = 0; aphase_cnt = 0;
    ph_pending = 1'b0; aw_pending = 1'b0;
    exp_base = base;
    hr_mode = 1; vld_mode = 0;
    apb_write(3'd0, base);
    apb_write(3'd2, 32'(stream.size()));
    hr_mode = hr; vld_mode = vld;
    apb_write(3'd1, 32'h1);
  endtask

  task automatic finish_xfer();
    int k;
    int n;
    n = stream.size();
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      cyc();
      k++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'h1);
    cyc(); cyc();
    check("done_once", 32'(done_cnt), 32'h1);
    check("write_count", 32'(wr_i), 32'(n));
    check("consumed", 32'(cons_i), 32'(n));
    check("addr_phases", 32'(aphase_cnt), 32'(n));
    apb_read(3'd2, rd); check("len_after", rd, 32'h0);
    apb_read(3'd1, rd); check("ctrl_after", rd, 32'h0);
    apb_read(3'd3, rd); check("status_after", rd, {16'(n), 16'h0});
    apb_read(3'd0, rd); check("wraddr_after", rd, exp_base + 32'(2 * n));
  endtask

  task automatic wait_addr_accept();
    int k;
    k = 0;
    while (!ph_pending && k < 50) begin
      cyc();
      k++;
    end
    check("addr_accept_seen", 32'(ph_pending), 32'h1);
  endtask

  initial begin
    hr_mode = 1; vld_mode = 0; cyc_n = 0;
    cons_i = 0; wr_i = 0; done_cnt = 0; aphase_cnt = 0;
    ph_pending = 1'b0; aw_pending = 1'b0; exp_base = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rdy", 32'(data_in_rdy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    rst = 1'b0;
    apb_read(3'd0, rd); check("rst_wraddr", rd, RST_ADDR);
    apb_read(3'd1, rd); check("rst_ctrl", rd, 32'h0);
    apb_read(3'd2, rd); check("rst_len", rd, 32'h0);
    apb_read(3'd3, rd); check("rst_status", rd, 32'h0);
    apb_read(3'd5, rd); check("undecoded", rd, 32'h0);
    apb_write(3'd0, 32'h0000_0123);
    apb_read(3'd0, rd); check("wraddr_bit0", rd, 32'h0000_0122);

    // Basic three-halfword transfer, zero-wait bus, always-valid stream
    stream = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    start_xfer(32'h0000_0100, 1, 1);
    finish_xfer();

    // Gapped stream and random bus waits
    stream = '{16'h1357, 16'h2468, 16'h9ABC};
    start_xfer(32'h0000_0100, 2, 3);
    finish_xfer();

    // Address wrap
    stream = '{16'($urandom), 16'($urandom)};
    start_xfer(32'hFFFF_FFFE, 2, 2);
    finish_xfer();

    // Zero length: no bus activity, done one cycle after start is set
    stream.delete();
    start_xfer(32'h0000_0200, 1, 1);
    check("len0_done_early", 32'(done), 32'h0);
    cyc();
    check("len0_done_pulse", 32'(done), 32'h1);
    cyc();
    check("len0_done_drop", 32'(done), 32'h0);
    repeat (4) cyc();
    check("len0_no_bus", 32'(aphase_cnt), 32'h0);
    check("len0_done_once", 32'(done_cnt), 32'h1);
    apb_read(3'd1, rd); check("len0_ctrl", rd, 32'h0);

    // Abort while fetching: stream never valid
    stream = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    start_xfer(32'h0000_0400, 1, 0);
    repeat (3) cyc();
    check("fetch_rdy", 32'(data_in_rdy), 32'h1);
    apb_write(3'd1, 32'h0);
    check("fetch_abort_rdy", 32'(data_in_rdy), 32'h0);
    cyc();
    check("fetch_abort_rdy2", 32'(data_in_rdy), 32'h0);
    apb_read(3'd2, rd); check("fetch_abort_len", rd, 32'h4);
    apb_read(3'd3, rd); check("fetch_abort_status", rd, 32'h0);
    check("fetch_abort_writes", 32'(aphase_cnt + cons_i + done_cnt), 32'h0);

    // Abort during a stalled data phase: the write still completes
    stream = '{16'hBEEF, 16'hCAFE, 16'hF00D};
    start_xfer(32'h0000_0500, 1, 1);
    wait_addr_accept();
    hr_mode = 0;
    cyc();
    apb_write(3'd1, 32'h0);
    hr_mode = 1;
    repeat (4) cyc();
    check("dabort_writes", 32'(wr_i), 32'h1);
    check("dabort_no_done", 32'(done_cnt), 32'h0);
    apb_read(3'd0, rd); check("dabort_wraddr", rd, 32'h0000_0502);
    apb_read(3'd2, rd); check("dabort_len", rd, 32'h2);
    apb_read(3'd3, rd); check("dabort_status", rd, 32'h0001_0000);

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 8);
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(16'($urandom));
      start_xfer({$urandom} & 32'hFFFF_FFFE, 2, 2);
      finish_xfer();
    end

    // Reset in the middle of a data phase
    stream = '{16'h5A5A, 16'hA5A5};
    start_xfer(32'h0000_0300, 1, 1);
    wait_addr_accept();
    hr_mode = 0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("mrst_htrans", 32'(HTRANS), 32'h0);
    check("mrst_hwdata", HWDATA, 32'h0);
    check("mrst_rdy", 32'(data_in_rdy), 32'h0);
    check("mrst_prdata", PRDATA, 32'h0);
    rst = 1'b0;
    hr_mode = 1;
    apb_read(3'd0, rd); check("mrst_wraddr", rd, RST_ADDR);
    apb_read(3'd1, rd); check("mrst_ctrl", rd, 32'h0);
    apb_read(3'd2, rd); check("mrst_len", rd, 32'h0);
    apb_read(3'd3, rd); check("mrst_status", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
